// File: rtl/compress_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : compress_pkg
//  Description : Shared definitions for the line compression controller:
//                pattern-code encoding, per-code encoded lengths, the
//                worst-case word size and the controller FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package compress_pkg;

    // Pattern codes produced by the per-word classifier.
    typedef enum logic [2:0] {
        PAT_ZZZZ = 3'b000,
        PAT_MMMM = 3'b001,
        PAT_ZZZX = 3'b010,
        PAT_MMMX = 3'b011,
        PAT_MMXX = 3'b100,
        PAT_XXXX = 3'b101
    } pat_code_e;

    // Encoded size in bits for each pattern code.
    localparam int c_LEN_ZZZZ = 2;
    localparam int c_LEN_MMMM = 6;
    localparam int c_LEN_ZZZX = 12;
    localparam int c_LEN_MMMX = 16;
    localparam int c_LEN_MMXX = 24;
    localparam int c_LEN_XXXX = 34;

    // Worst-case encoded word: 2-bit code + raw 32-bit word.
    localparam int c_MAX_WORD_BITS = 34;

    // Number of legal pattern codes.
    localparam int c_NUM_CODES = 6;

    // Controller FSM state encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } lcc_state_e;

    // Codes 110/111 are not produced by a healthy classifier.
    function automatic logic is_valid_code(input logic [2:0] code);
        return (code <= 3'b101);
    endfunction

    // Codes that leave a word not fully matched by the dictionary get
    // pushed so later words can match against them.
    function automatic logic is_push_code(input logic [2:0] code);
        logic w_push;
        case (code)
            PAT_MMMX, PAT_MMXX, PAT_XXXX: w_push = 1'b1;
            default:                      w_push = 1'b0;
        endcase
        return w_push;
    endfunction

endpackage : compress_pkg
`default_nettype wire

// File: rtl/lcc_stat_counters.sv
`default_nettype none
// ============================================================================
//  Module      : lcc_stat_counters
//  Description : Six saturating 8-bit hit counters, one per legal pattern
//                code. Cumulative across lines; cleared only by reset.
//                Used by line_compress_ctrl when LINE_COMPRESS_STATS_EN is
//                defined.
//  Ports       : i_clk    - clock
//                i_reset  - synchronous active-high reset
//                i_hit    - one accepted, legal classifier result this cycle
//                i_code   - pattern code of that result
//                o_cnt    - per-code hit counts
//  Revision    : 1.0  initial release
// ============================================================================
module lcc_stat_counters
    import compress_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_hit,
    input  logic [2:0] i_code,
    output logic [7:0] o_cnt [c_NUM_CODES]
);

    logic [7:0] r_cnt [c_NUM_CODES];

    generate
        for (genvar g = 0; g < c_NUM_CODES; g++) begin : g_cnt
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_cnt[g] <= 8'd0;
                end else if (i_hit && (i_code == 3'(g)) && (r_cnt[g] != 8'hFF)) begin
                    r_cnt[g] <= r_cnt[g] + 8'd1;
                end
            end
            assign o_cnt[g] = r_cnt[g];
        end
    endgenerate

endmodule : lcc_stat_counters
`default_nettype wire

// File: rtl/line_compress_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : line_compress_ctrl
//  Description : Sequences compression of one cache line through the
//                per-word pattern classifier. Accepts a line, clears the
//                dictionary, requests words one at a time, accumulates the
//                encoded lengths, drives dictionary pushes and reports the
//                total size and compressibility of the line.
//  Ports       : i_clk / i_reset        - clock, synchronous active-high reset
//                i_line_valid/o_line_ready - line handshake (accept in IDLE)
//                o_dict_clear           - 1-cycle dictionary clear pulse
//                o_word_req/o_word_idx  - 1-cycle word classify request
//                i_code_valid/i_encoded/i_length - classifier result
//                o_dict_push            - push current word (comb. in WAIT)
//                o_result_valid/i_result_ready - result handshake
//                o_total_bits/o_compressible/o_code_err - line result
//                o_stat_cnt             - per-code hit counters (optional)
//  Config      : LINE_COMPRESS_STATS_EN - adds lcc_stat_counters and the
//                o_stat_cnt port.
//  Revision    : 1.0  initial release
// ============================================================================
module line_compress_ctrl
    import compress_pkg::*;
#(
    parameter int WORDS_PER_LINE = 16,
    parameter int THRESHOLD_BITS = 256,
    parameter int TOT_W          = $clog2(WORDS_PER_LINE * 34 + 1),
    parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_line_valid,
    output logic             o_line_ready,
    output logic             o_dict_clear,
    output logic             o_word_req,
    output logic [IDX_W-1:0] o_word_idx,
    input  logic             i_code_valid,
    input  logic [2:0]       i_encoded,
    input  logic [5:0]       i_length,
    output logic             o_dict_push,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic [TOT_W-1:0] o_total_bits,
    output logic             o_compressible,
`ifdef LINE_COMPRESS_STATS_EN
    output logic [7:0]       o_stat_cnt [c_NUM_CODES],
`endif
    output logic             o_code_err
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    lcc_state_e       r_state;
    lcc_state_e       w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic [TOT_W-1:0] r_total;
    logic             r_err;

    logic             w_code_ok;
    logic             w_take;
    logic [5:0]       w_add_len;

    // A result is consumed only while waiting for one.
    assign w_take    = (r_state == ST_WAIT) && i_code_valid;
    assign w_code_ok = is_valid_code(i_encoded);
    // Illegal codes are charged as an uncompressed word.
    assign w_add_len = w_code_ok ? i_length : 6'(c_MAX_WORD_BITS);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (i_line_valid) w_next_state = ST_CLEAR;
            ST_CLEAR:  w_next_state = ST_REQ;
            ST_REQ:    w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (i_code_valid) begin
                    w_next_state = (r_idx == c_LAST_IDX) ? ST_RESULT : ST_REQ;
                end
            end
            ST_RESULT: if (i_result_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (state decode; push is the only input-dependent one)
    // ------------------------------------------------------------------
    always_comb begin
        o_line_ready   = (r_state == ST_IDLE);
        o_dict_clear   = (r_state == ST_CLEAR);
        o_word_req     = (r_state == ST_REQ);
        o_result_valid = (r_state == ST_RESULT);
        o_dict_push    = w_take && is_push_code(i_encoded);
    end

    // ------------------------------------------------------------------
    // Datapath: word index, length accumulator and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx   <= '0;
            r_total <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && i_line_valid) begin
                r_idx   <= '0;
                r_total <= '0;
                r_err   <= 1'b0;
            end else if (w_take) begin
                r_total <= r_total + TOT_W'(w_add_len);
                if (!w_code_ok) begin
                    r_err <= 1'b1;
                end
                // Index stays on the last word so it remains meaningful
                // while the result is held.
                if (r_idx != c_LAST_IDX) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign o_word_idx   = r_idx;
    assign o_total_bits = r_total;
    assign o_code_err   = r_err;
    // Only meaningful while a result is presented; low otherwise so the
    // reset value is not reported as compressible.
    assign o_compressible = (r_state == ST_RESULT) &&
        ({{(32 - TOT_W){1'b0}}, r_total} <= 32'(THRESHOLD_BITS));

`ifdef LINE_COMPRESS_STATS_EN
    lcc_stat_counters u_stats (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_hit   (w_take && w_code_ok),
        .i_code  (i_encoded),
        .o_cnt   (o_stat_cnt)
    );
`endif

endmodule : line_compress_ctrl
`default_nettype wire
